// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a runtime-loadable pattern and length,
// a registered detection pulse, selectable overlap behaviour and a saturating hit counter.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter int               OVERLAP = 1,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b0101,
  parameter int               RST_LEN = 3,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_in,
  input  logic             seq_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cnt_clr,
  output logic             det_o,
  output logic [CNT_W-1:0] det_count,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FULL    = LEN_W'(PAT_W);
  localparam logic             RST_ERR = (RST_LEN == 0) || (RST_LEN > PAT_W);

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic             err_q,  err_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             det_q,  det_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic             match;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end

    hist_shift = {hist_q[PAT_W-2:0], seq_in};
    fill_inc   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

    // A load in the same cycle discards the sample, so it can never complete a match.
    match = seq_valid && !cfg_load && !err_q && (fill_inc >= len_q) &&
            (((hist_shift ^ pat_q) & mask) == '0);

    pat_d  = pat_q;
    len_d  = len_q;
    err_d  = err_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = match;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = cfg_len;
      err_d  = (cfg_len == '0) || (cfg_len > FULL);
      hist_d = '0;
      fill_d = '0;
    end else if (seq_valid) begin
      hist_d = hist_shift;
      fill_d = (match && (OVERLAP == 0)) ? '0 : fill_inc;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= RST_PAT;
      len_q  <= LEN_W'(RST_LEN);
      err_q  <= RST_ERR;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      err_q  <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign det_o     = det_q;
  assign det_count = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (defaults, non-overlapping, 2-bit
// counter) share one stimulus stream; expected outputs are queued per step and popped after each edge.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seq_in, seq_valid, cfg_load, cnt_clr;
  logic [3:0] cfg_pat;
  logic [2:0] cfg_len;

  logic       det_a, det_b, det_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       err_a, err_b, err_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    sel;
    int    det;
    int    cnt;
    int    err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_detect_param dut_a (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_valid(seq_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .det_o(det_a), .det_count(cnt_a), .cfg_err(err_a)
  );

  seq_detect_param #(.OVERLAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_valid(seq_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .det_o(det_b), .det_count(cnt_b), .cfg_err(err_b)
  );

  seq_detect_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_valid(seq_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .det_o(det_c), .det_count(cnt_c), .cfg_err(err_c)
  );

  task automatic check(string tag, logic [31:0] obs, int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(logic v, logic b, logic ld = 1'b0, logic clr = 1'b0);
    seq_valid = v;
    seq_in    = b;
    cfg_load  = ld;
    cnt_clr   = clr;
  endtask

  // cnt / err of -1 means "not checked on this step"
  task automatic expect_out(string tag, int sel, int det, int cnt = -1, int err = -1);
    exp_t e;
    e.tag = tag; e.sel = sel; e.det = det; e.cnt = cnt; e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] od, oc, oe;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin od = 32'(det_a); oc = 32'(cnt_a); oe = 32'(err_a); end
        1:       begin od = 32'(det_b); oc = 32'(cnt_b); oe = 32'(err_b); end
        default: begin od = 32'(det_c); oc = 32'(cnt_c); oe = 32'(err_c); end
      endcase
      check({e.tag, "_det"}, od, e.det);
      if (e.cnt >= 0) check({e.tag, "_cnt"}, oc, e.cnt);
      if (e.err >= 0) check({e.tag, "_err"}, oe, e.err);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_det_a"}, 32'(det_a), 0);
    check({tag, "_cnt_a"}, 32'(cnt_a), 0);
    check({tag, "_err_a"}, 32'(err_a), 0);
    check({tag, "_det_c"}, 32'(det_c), 0);
    check({tag, "_cnt_c"}, 32'(cnt_c), 0);
  endtask

  initial begin
    int s_bit[5]  = '{1, 0, 1, 0, 1};
    int a_det[5]  = '{0, 0, 1, 0, 1};
    int a_cnt[5]  = '{0, 0, 1, 1, 2};
    int b_det[5]  = '{0, 0, 1, 0, 0};
    int b_cnt[5]  = '{0, 0, 1, 1, 1};
    int g_val[6]  = '{1, 1, 0, 0, 1, 1};
    int g_bit[6]  = '{1, 1, 0, 0, 0, 1};
    int g_det[6]  = '{0, 0, 0, 0, 0, 1};
    int k;

    rst_n = 1'b1;
    drive(1'b0, 1'b0);
    cfg_pat = '0;
    cfg_len = '0;
    #1 rst_n = 1'b0;
    #11;
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Default pattern 101 on 1,0,1,0,1: overlapping vs non-overlapping
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'(s_bit[i]));
      expect_out("ovl1", 0, a_det[i], a_cnt[i], 0);
      expect_out("ovl0", 1, b_det[i], b_cnt[i], 0);
      tick();
    end
    drive(1'b0, 1'b1);
    expect_out("idle", 0, 0, 2);
    expect_out("idle", 1, 0, 1);
    tick();

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr", 0, 0, 0);
    expect_out("clr", 1, 0, 0);
    expect_out("clr", 2, 0, 0);
    tick();

    // Load 1101/4 together with a sample (sample is dropped), then 1,1,gap,gap,0,1
    cfg_pat = 4'b1101;
    cfg_len = 3'd4;
    drive(1'b1, 1'b1, 1'b1);
    expect_out("ld4", 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'(g_val[i]), 1'(g_bit[i]));
      expect_out("gap", 0, g_det[i], g_det[i]);
      expect_out("gap", 1, g_det[i]);
      tick();
    end

    // Reload with a sample: if the sample were kept, 1,1,0,1 would complete
    drive(1'b1, 1'b1, 1'b1);
    expect_out("ldsamp", 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'(s_bit[i]));
      expect_out("ldsamp", 0, 0, 1);
      tick();
    end

    // Length 3 with pattern 1101: bit 3 is ignored, effective pattern 101
    cfg_len = 3'd3;
    drive(1'b0, 1'b0, 1'b1);
    expect_out("len3", 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'(s_bit[i]));
      expect_out("len3", 0, a_det[i], 1 + a_det[i]);
      tick();
    end

    // Invalid lengths: 0 and 5 (> PAT_W) never detect
    cfg_pat = 4'b0000;
    cfg_len = 3'd0;
    drive(1'b0, 1'b0, 1'b1);
    expect_out("len0", 0, 0, 2, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      expect_out("len0_rand", 0, 0, 2, 1);
      tick();
    end
    cfg_pat = 4'b1111;
    cfg_len = 3'd5;
    drive(1'b0, 1'b0, 1'b1);
    expect_out("len5", 0, 0, 2, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      expect_out("len5_ones", 0, 0, 2, 1);
      tick();
    end

    // Back to 101/3; saturation of the 2-bit counter
    cfg_pat = 4'b0101;
    cfg_len = 3'd3;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("restore", 0, 0, 0, 0);
    expect_out("restore", 2, 0, 0, 0);
    tick();
    k = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'(i % 2 == 0));
      if (i >= 2 && i % 2 == 0) k++;
      expect_out("sat", 2, (i >= 2 && i % 2 == 0) ? 1 : 0, (k > 3) ? 3 : k);
      expect_out("sat", 0, (i >= 2 && i % 2 == 0) ? 1 : 0, k);
      tick();
    end
    drive(1'b1, 1'b0);
    expect_out("sat_hold", 2, 0, 3);
    expect_out("sat_hold", 0, 0, 5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    expect_out("clr_hit", 2, 1, 0);
    expect_out("clr_hit", 0, 1, 0);
    tick();

    // Mid-stream reset discards 1,0 so the following 1 cannot complete 101
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'(s_bit[i]));
      expect_out("prerst", 0, 0, 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'(s_bit[i]));
      expect_out("postrst", 0, a_det[i], a_cnt[i], 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
